// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game pixel pipeline.
// Holds the game state enum, visible screen size and sprite colours.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int H_VIS = 640;
  localparam int V_VIS = 480;

  localparam logic [11:0] COLOR_FG_D  = 12'h555;
  localparam logic [11:0] COLOR_BG_D  = 12'hFFF;
  localparam logic [11:0] COLOR_HIT_D = 12'hF00;

endpackage

// File: rtl/collision_ctrl_sync_edge.sv
// Two-flop synchroniser with a history flop, emitting a one-cycle edge pulse.
// Ports: clkdiv, RESET (async high), d (async level), pulse (RISE ? rising : falling edge).
module sync_edge #(
  parameter bit RISE = 1'b1
) (
  input  logic clkdiv,
  input  logic RESET,
  input  logic d,
  output logic pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  always_ff @(posedge clkdiv or posedge RESET) begin
    if (RESET) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign pulse = RISE ? (sync_q & ~hist_q) : (~sync_q & hist_q);

endmodule

// File: rtl/collision_ctrl.sv
// Sprite overlap detection, game FSM, score/speed keeping and pixel colour mux.
// Ports: clkdiv/RESET, START, fresh, row/col, sprite masks -> status, speed, score, crash, rgb.
module collision_ctrl
  import dino_pkg::*;
#(
  parameter logic [3:0]  SPEED_MIN       = 4'd2,
  parameter logic [3:0]  SPEED_MAX       = 4'd9,
  parameter logic [15:0] FRAMES_PER_STEP = 16'd600,
  parameter logic [11:0] COLOR_FG        = COLOR_FG_D,
  parameter logic [11:0] COLOR_BG        = COLOR_BG_D,
  parameter logic [11:0] COLOR_HIT       = COLOR_HIT_D
) (
  input  logic        clkdiv,
  input  logic        RESET,
  input  logic        START,
  input  logic        fresh,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        cactus_px,
  input  logic        dino_px,
  output logic        game_status,
  output logic [3:0]  speed,
  output logic [15:0] score,
  output logic        crash,
  output logic [11:0] rgb
);

  localparam logic [8:0] V_LIM = 9'(V_VIS);
  localparam logic [9:0] H_LIM = 10'(H_VIS);

  logic start_rise;
  logic frame_end;

  sync_edge #(.RISE(1'b1)) u_start (
    .clkdiv (clkdiv),
    .RESET  (RESET),
    .d      (START),
    .pulse  (start_rise)
  );

  sync_edge #(.RISE(1'b0)) u_fresh (
    .clkdiv (clkdiv),
    .RESET  (RESET),
    .d      (fresh),
    .pulse  (frame_end)
  );

  state_t      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [3:0]  speed_q, speed_d;
  logic [15:0] cnt_q, cnt_d;
  logic        hit_q, hit_d;
  logic        status_q, status_d;
  logic        crash_q, crash_d;
  logic [11:0] rgb_q, rgb_d;

  logic       visible;
  logic       hit_now;
  logic       hit_any;
  logic [4:0] spd_inc;

  assign visible = (row_addr < V_LIM) && (col_addr < H_LIM);
  assign hit_now = visible & cactus_px & dino_px;
  // A hit landing on the frame_end cycle still belongs to the ending frame.
  assign hit_any = hit_q | hit_now;
  assign spd_inc = {1'b0, speed_q} + 5'd1;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    hit_d   = frame_end ? 1'b0 : hit_any;
    unique case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          state_d = RUN;
          score_d = '0;
          speed_d = SPEED_MIN;
          cnt_d   = '0;
          hit_d   = 1'b0;
        end
      end
      RUN: begin
        if (frame_end) begin
          if (hit_any) begin
            state_d = OVER;
          end else begin
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
            if (cnt_q == FRAMES_PER_STEP - 16'd1) begin
              cnt_d   = '0;
              speed_d = (spd_inc > {1'b0, SPEED_MAX}) ?
                        SPEED_MAX : spd_inc[3:0];
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status_d = (state_q == RUN);
    crash_d  = (state_q == OVER);
    rgb_d    = COLOR_BG;
    if (!visible) begin
      rgb_d = 12'h000;
    end else if (cactus_px & dino_px) begin
      rgb_d = COLOR_HIT;
    end else if (cactus_px | dino_px) begin
      rgb_d = (state_q == OVER) ? COLOR_HIT : COLOR_FG;
    end
  end

  always_ff @(posedge clkdiv or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      score_q  <= '0;
      speed_q  <= SPEED_MIN;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      status_q <= 1'b0;
      crash_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      speed_q  <= speed_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      status_q <= status_d;
      crash_q  <= crash_d;
      rgb_q    <= rgb_d;
    end
  end

  assign game_status = status_q;
  assign crash       = crash_q;
  assign score       = score_q;
  assign speed       = speed_q;
  assign rgb         = rgb_q;

endmodule
